// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift-register command sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE
    } state_t;

    localparam int          WIDTH_DEF    = 4;
    localparam int          CNT_W_DEF    = 4;
    localparam logic [2:0]  HOLD_SEL_DEF = 3'b110;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable saturating down-counter used to time the shift phase.
module shift_seq_cnt
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] din,
    output logic             is_one,
    output logic             is_zero
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (en && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign is_one  = (count == ONE);
    assign is_zero = (count == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a universal shift register's in/Sel/load.
// Optional SHIFT_SEQ_ABORT_EN adds abort input and rsp_aborted output.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEF,
    parameter int         CNT_W    = CNT_W_DEF,
    parameter logic [2:0] HOLD_SEL = HOLD_SEL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [2:0]       cmd_sel,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_load,
    output logic [WIDTH-1:0] sr_in,
    output logic [2:0]       sr_sel,
    output logic             sr_load,
    input  logic [WIDTH-1:0] sr_result,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
    output logic             rsp_aborted,
`endif
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state, state_n;
    logic             accept;
    logic             abort_hit;
    logic             cnt_one, cnt_zero;
    logic [WIDTH-1:0] data_q, data_n, in_n;
    logic [2:0]       sel_q, sel_n;
    logic             load_n, shift_n;

    assign cmd_ready = (state == IDLE) && rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

`ifdef SHIFT_SEQ_ABORT_EN
    logic aborted_q;
    assign abort_hit = abort && ((state == LOAD) || (state == SHIFT));
`else
    assign abort_hit = 1'b0;
`endif

    shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .en      (state == SHIFT),
        .din     (cmd_cnt),
        .is_one  (cnt_one),
        .is_zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_load)             state_n = LOAD;
                    else if (cmd_cnt != '0)   state_n = SHIFT;
                    else                      state_n = CAPTURE;
                end
            end
            LOAD: begin
                if (abort_hit || cnt_zero) state_n = CAPTURE;
                else                       state_n = SHIFT;
            end
            SHIFT: begin
                if (abort_hit || cnt_one || cnt_zero) state_n = CAPTURE;
            end
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state so the shift register
    // sees them in the same cycle the FSM occupies that state.
    always_comb begin
        data_n  = accept ? cmd_data : data_q;
        load_n  = (state_n == LOAD);
        shift_n = (state_n == SHIFT);
        sel_n   = HOLD_SEL;
        in_n    = '0;
        if (shift_n) sel_n = accept ? cmd_sel : sel_q;
        if (load_n || shift_n) in_n = data_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q    <= '0;
            sel_q     <= '0;
            sr_in     <= '0;
            sr_sel    <= HOLD_SEL;
            sr_load   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (accept) begin
                data_q <= cmd_data;
                sel_q  <= cmd_sel;
            end
            sr_in     <= in_n;
            sr_sel    <= sel_n;
            sr_load   <= load_n;
            rsp_valid <= (state == CAPTURE);
            if (state == CAPTURE) rsp_data <= sr_result;
        end
    end

`ifdef SHIFT_SEQ_ABORT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            aborted_q   <= 1'b0;
            rsp_aborted <= 1'b0;
        end else begin
            if (accept)         aborted_q <= 1'b0;
            else if (abort_hit) aborted_q <= 1'b1;
            rsp_aborted <= (state == CAPTURE) && aborted_q;
        end
    end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a cycle-indexed result stub.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_data = '0;
    logic [2:0] cmd_sel = '0;
    logic [3:0] cmd_cnt = '0;
    logic       cmd_load = 1'b0;
    logic [3:0] sr_in;
    logic [2:0] sr_sel;
    logic       sr_load;
    logic [3:0] sr_result;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       busy;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_sel   (cmd_sel),
        .cmd_cnt   (cmd_cnt),
        .cmd_load  (cmd_load),
        .sr_in     (sr_in),
        .sr_sel    (sr_sel),
        .sr_load   (sr_load),
        .sr_result (sr_result),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen; cycle c lies after edge c
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] stub(input int unsigned c);
        logic [31:0] h;
        h = c * 32'd2654435761;
        return h[31:28] ^ h[3:0];
    endfunction

    assign sr_result = stub(cyc);

    typedef struct {
        int unsigned at;
        logic [3:0]  data;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    logic [3:0]  exp_last = '0;

    bit          cur_act = 0;
    int unsigned cur_t = 0;
    int unsigned cur_l = 0;
    int unsigned cur_n = 0;
    logic [3:0]  cur_d = '0;
    logic [2:0]  cur_s = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: a command occupies cycles T..T+L+N; first L are load,
    // next N are shift, last one is capture; response arrives one later.
    logic        m_ld, m_sh, m_bz;
    logic [2:0]  m_sel;
    logic [3:0]  m_in;
    int unsigned m_ph;
    rsp_t        m_e;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            m_bz = cur_act && (cyc >= cur_t) && (cyc <= cur_t + cur_l + cur_n);
            m_ph = cyc - cur_t;
            m_ld = m_bz && (cur_l == 1) && (m_ph == 0);
            m_sh = m_bz && (m_ph >= cur_l) && (m_ph < cur_l + cur_n);
            m_sel = m_sh ? cur_s : 3'b110;
            m_in  = (m_ld || m_sh) ? cur_d : 4'h0;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_cycle", cyc, m_e.at);
                    exp_last = m_e.data;
                end
            end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                m_e = exp_q.pop_front();
                chk("missing_rsp", 0, 1);
            end
            chk("rsp_data", rsp_data, exp_last);
            chk("sr_load", sr_load, m_ld);
            chk("sr_sel", sr_sel, m_sel);
            chk("sr_in", sr_in, m_in);
            chk("busy", busy, m_bz);
        end
    end

    task automatic send(input logic [3:0] d, input logic [2:0] s,
                        input int unsigned n, input bit l);
        int k;
        int unsigned t;
        cmd_data  = d;
        cmd_sel   = s;
        cmd_cnt   = n[3:0];
        cmd_load  = l;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        cur_act = 1;
        cur_t = t;
        cur_l = l;
        cur_n = n;
        cur_d = d;
        cur_s = s;
        exp_q.push_back('{at: t + l + n + 1, data: stub(t + l + n)});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", cmd_ready, 0);
        mon_en = 1;
        rst = 1'b1;
        @(negedge clk);

        send(4'b1010, 3'b000, 0, 1);
        repeat (2) @(negedge clk);
        send(4'b0101, 3'b011, 3, 0);
        @(negedge clk);
        send(4'b1111, 3'b001, 0, 0);
        send(4'b0110, 3'b010, 2, 1);
        send(4'b1001, 3'b100, 1, 0);
        send(4'b0011, 3'b111, 15, 1);

        send(4'b1100, 3'b001, 15, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        cur_act = 0;
        exp_q.delete();
        exp_last = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            send(4'($urandom), 3'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                             : $urandom_range(0, 3),
                 1'($urandom));
            w = $urandom_range(0, 2);
            repeat (w) @(negedge clk);
        end

        w = 0;
        while (exp_q.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
